turf_ram_sched: RTL and testbench
=================================

# turf_ram_sched

Game-phase sequencer and port arbiter for the single-port paint RAM. It owns the RAM write/read port for a whole round: it clears the field, time-multiplexes the four player paint writes during play, sweeps the RAM to tally each colour when the round timer expires, then publishes per-player counts and the winner. It sits between the player movement/direction logic, the rate-divider tick pulses and the paint RAM.

## Interface
- ADDR_W, 15: RAM address width; address = {x[7:0], y[6:0]}.
- LAST_ADDR, 15'h4F77: highest swept/cleared address (x=158, y=119).
- ROUND_SECS, 60: round length in sec_tick pulses; must be ≤255.

- CLOCK_50  in  1  system clock; all logic on the rising edge.
- resetn  in  1  synchronous reset, active low.
- start  in  1  one-cycle pulse; begins a round from IDLE or DONE.
- move_tick  in  1  one-cycle pulse per movement step.
- sec_tick  in  1  one-cycle pulse per second.
- p1, p2, p3, p4  in  15 each  current player positions.
- ram_rdata  in  3  RAM read data; registered, valid one cycle after address.
- ram_wren  out  1  RAM write enable.
- ram_addr  out  15  RAM address.
- ram_wdata  out  3  RAM write data.
- running  out  1  high in RUN/WRITE.
- done  out  1  high in DONE; results are valid.
- time_left  out  8  remaining seconds.
- p1_count, p2_count, p3_count, p4_count  out  15 each  tile tallies.
- winner  out  2  0..3 = player 1..4.

## Operation
- Colour codes: P1=3'b001, P2=3'b010, P3=3'b100, P4=3'b110, blank=3'b000; other codes are counted for nobody.
- States: IDLE, CLEAR, RUN, WRITE, SWEEP, DRAIN, DONE.
- IDLE: wren=0; on start → CLEAR.
- CLEAR: writes blank to addresses 0..LAST_ADDR, one per cycle; zero the counts and load time_left=ROUND_SECS on entry; after LAST_ADDR → RUN.
- RUN: on move_tick, snapshot p1..p4 and go to WRITE.
- WRITE: 4 cycles, index 0..3: address = snapshot[i], data = colour of player i+1, wren=1. Then → RUN, or → SWEEP if time_left==0.
- sec_tick in RUN/WRITE decrements time_left (saturating at 0). When time_left==0 in RUN → SWEEP; in WRITE, the burst completes first.
- A move_tick during WRITE sets a 1-deep pending flag; a fresh burst begins immediately after (fresh snapshot). Further ticks while the flag is set are dropped. The flag is cleared on entering SWEEP.
- SWEEP: ram_addr steps 0..LAST_ADDR, one per cycle, with wren=0. ram_rdata seen in each cycle is tallied against the address of the previous cycle. The first SWEEP cycle tallies nothing. After LAST_ADDR is issued → DRAIN.
- DRAIN: 1 cycle; tallies the final word, then → DONE.
- DONE: winner is the player with the maximum count. Ties go to the highest-numbered tied player (all counts equal → 3). winner and counts hold until the next start (→ CLEAR).
- start is ignored outside IDLE/DONE. move_tick/sec_tick are ignored outside RUN/WRITE.
- Count width is 15 bits. The maximum tally of 20344 cannot overflow.

## Timing
- Reset values: state=IDLE, wren=0, addr=0, wdata=0, running=0, done=0, time_left=0, all counts=0, winner=0, pending=0.
- start → first CLEAR write: next cycle.
- CLEAR lasts LAST_ADDR+1 = 20344 cycles.
- move_tick → first paint write: 1 cycle (WRITE entered on the next edge).
- Each burst lasts 4 cycles. A back-to-back pending burst adds no gap.
- SWEEP lasts 20344 cycles, plus 1 for DRAIN. done rises on the cycle after DRAIN, and winner is valid in that same cycle.
- All outputs are registered. resetn low at any point, mid-burst or mid-sweep, aborts to the reset values on the next edge.

## Structure
- Shared package turf_pkg holds:
  - the colour code constants;
  - LAST_ADDR;
  - the state enum;
  - the player index type.
  The movement and drawing logic reuse these.
- Sub-module winner_select: combinational max-of-four over the counts with the tie rule. It is registered into winner on entry to DONE.

## Test plan
- Reset, then start → 20344 writes of 3'b000 at addresses 0..0x4F77 → running=1, time_left=60.
- In RUN with p1=0x4EF6, p2=0x0082, p3=0x4E82, p4=0x00F6, pulse move_tick → four consecutive writes (0x4EF6,001), (0x0082,010), (0x4E82,100), (0x00F6,110).
- Second move_tick 2 cycles into a burst → a second burst starts the cycle after the first ends. A third tick inside that window is dropped.
- ROUND_SECS=2, paint 5 P3 and 3 P1 tiles, with sec_tick landing mid-burst → burst completes, sweep reads all addresses → p3_count=5, p1_count=3, winner=2, done=1.
- Equal counts for P1 and P2 with others lower → winner=1. All counts zero → winner=3.
- Assert resetn low mid-SWEEP → next cycle state=IDLE, counts=0, done=0. Then start → CLEAR restarts at address 0.

Source files
------------

// File: rtl/turf_pkg.sv
// Shared definitions for the turf paint game: colour codes, field extent,
// sequencer states and player indexing.
package turf_pkg;

  localparam logic [2:0] COL_BLANK = 3'b000;
  localparam logic [2:0] COL_P1    = 3'b001;
  localparam logic [2:0] COL_P2    = 3'b010;
  localparam logic [2:0] COL_P3    = 3'b100;
  localparam logic [2:0] COL_P4    = 3'b110;

  localparam logic [14:0] LAST_ADDR = 15'h4F77;
  localparam int          CNT_W     = 15;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_WRITE, S_SWEEP, S_DRAIN, S_DONE
  } state_t;

  typedef logic [1:0] player_t;

  function automatic logic [2:0] player_colour(player_t p);
    case (p)
      2'd0:    return COL_P1;
      2'd1:    return COL_P2;
      2'd2:    return COL_P3;
      default: return COL_P4;
    endcase
  endfunction

endpackage

// File: rtl/turf_ram_sched_if.sv
// Single-port paint RAM bus: the scheduler drives address/write side,
// the RAM returns registered read data one cycle after the address.
interface turf_ram_sched_if #(parameter int ADDR_W = 15);
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_addr;
  logic [2:0]        ram_wdata;
  logic [2:0]        ram_rdata;

  modport master (output ram_wren, ram_addr, ram_wdata, input ram_rdata);
  modport slave  (input ram_wren, ram_addr, ram_wdata, output ram_rdata);
endinterface

// File: rtl/turf_ram_sched_winner_select.sv
// Combinational max-of-four over the player tallies; ties resolve to the
// highest-numbered player.
module winner_select
  import turf_pkg::*;
(
  input  logic [3:0][CNT_W-1:0] counts,
  output player_t               winner
);

  logic [CNT_W-1:0] best;

  // Scan from player 4 downward with a strict compare so ties keep the higher player.
  always_comb begin
    winner = 2'd3;
    best   = counts[3];
    if (counts[2] > best) begin winner = 2'd2; best = counts[2]; end
    if (counts[1] > best) begin winner = 2'd1; best = counts[1]; end
    if (counts[0] > best) begin winner = 2'd0; best = counts[0]; end
  end

endmodule

// File: rtl/turf_ram_sched.sv
// Round sequencer and paint-RAM port owner: clear, timed four-player paint
// bursts, post-round sweep tally and winner publication.
module turf_ram_sched #(
  parameter int                ADDR_W     = 15,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = turf_pkg::LAST_ADDR,
  parameter int                ROUND_SECS = 60
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         move_tick,
  input  logic                         sec_tick,
  input  logic [ADDR_W-1:0]            p1,
  input  logic [ADDR_W-1:0]            p2,
  input  logic [ADDR_W-1:0]            p3,
  input  logic [ADDR_W-1:0]            p4,
  turf_ram_sched_if.master             bus,
  output logic                         running,
  output logic                         done,
  output logic [7:0]                   time_left,
  output logic [turf_pkg::CNT_W-1:0]   p1_count,
  output logic [turf_pkg::CNT_W-1:0]   p2_count,
  output logic [turf_pkg::CNT_W-1:0]   p3_count,
  output logic [turf_pkg::CNT_W-1:0]   p4_count,
  output turf_pkg::player_t            winner
);
  import turf_pkg::*;

  state_t                   state;
  player_t                  idx;
  player_t                  idx_nxt;
  logic                     pending;
  logic [3:0][ADDR_W-1:0]   snap;
  logic [3:0][CNT_W-1:0]    cnt;
  logic [3:0][CNT_W-1:0]    cnt_nxt;
  logic                     tally_en;
  player_t                  win_nxt;

  assign idx_nxt = idx + 2'd1;

  // Read data lags the address by one cycle, so the first sweep cycle has nothing to count.
  assign tally_en = ((state == S_SWEEP) && (bus.ram_addr != '0)) || (state == S_DRAIN);

  always_comb begin
    cnt_nxt = cnt;
    if (tally_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ram_rdata == player_colour(player_t'(i)))
          cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  winner_select u_winner_select (
    .counts (cnt_nxt),
    .winner (win_nxt)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state         <= S_IDLE;
      idx           <= '0;
      pending       <= 1'b0;
      bus.ram_wren  <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= COL_BLANK;
      running       <= 1'b0;
      done          <= 1'b0;
      time_left     <= '0;
      cnt           <= '0;
      winner        <= '0;
    end else begin
      if ((state == S_RUN || state == S_WRITE) && sec_tick && time_left != 8'd0)
        time_left <= time_left - 8'd1;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_CLEAR;
            bus.ram_wren  <= 1'b1;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= COL_BLANK;
            cnt           <= '0;
            time_left     <= 8'(ROUND_SECS);
            done          <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (bus.ram_addr == LAST_ADDR) begin
            state        <= S_RUN;
            bus.ram_wren <= 1'b0;
            running      <= 1'b1;
          end else begin
            bus.ram_addr <= bus.ram_addr + 1'b1;
          end
        end
        S_RUN: begin
          if (time_left == 8'd0) begin
            state        <= S_SWEEP;
            bus.ram_wren <= 1'b0;
            bus.ram_addr <= '0;
            running      <= 1'b0;
            pending      <= 1'b0;
          end else if (move_tick) begin
            state         <= S_WRITE;
            snap          <= {p4, p3, p2, p1};
            idx           <= '0;
            bus.ram_wren  <= 1'b1;
            bus.ram_addr  <= p1;
            bus.ram_wdata <= COL_P1;
          end
        end
        S_WRITE: begin
          if (idx != 2'd3) begin
            idx           <= idx_nxt;
            bus.ram_addr  <= snap[idx_nxt];
            bus.ram_wdata <= player_colour(idx_nxt);
            if (move_tick)
              pending <= 1'b1;
          end else if (time_left == 8'd0) begin
            state        <= S_SWEEP;
            bus.ram_wren <= 1'b0;
            bus.ram_addr <= '0;
            running      <= 1'b0;
            pending      <= 1'b0;
          end else if (pending || move_tick) begin
            // Back-to-back burst from a fresh snapshot; a tick landing here while pending is dropped.
            snap          <= {p4, p3, p2, p1};
            idx           <= '0;
            bus.ram_addr  <= p1;
            bus.ram_wdata <= COL_P1;
            pending       <= 1'b0;
          end else begin
            state        <= S_RUN;
            bus.ram_wren <= 1'b0;
          end
        end
        S_SWEEP: begin
          cnt <= cnt_nxt;
          if (bus.ram_addr == LAST_ADDR)
            state <= S_DRAIN;
          else
            bus.ram_addr <= bus.ram_addr + 1'b1;
        end
        S_DRAIN: begin
          cnt    <= cnt_nxt;
          winner <= win_nxt;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign p1_count = cnt[0];
  assign p2_count = cnt[1];
  assign p3_count = cnt[2];
  assign p4_count = cnt[3];

endmodule

// File: tb/tb_turf_ram_sched.sv
// Directed bench for turf_ram_sched with a queue-based round model and a
// per-cycle compare process.
module tb_turf_ram_sched;

  localparam int LAST  = 15'h4F77;
  localparam int ROUND = 60;
  localparam int P_IDLE = 0, P_CLEAR = 1, P_PLAY = 2, P_SWEEP = 3, P_DRAIN = 4, P_DONE = 5;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0, move_tick = 1'b0, sec_tick = 1'b0;
  logic [14:0] p1 = '0, p2 = '0, p3 = '0, p4 = '0;
  logic        running, done;
  logic [7:0]  time_left;
  logic [14:0] p1_count, p2_count, p3_count, p4_count;
  logic [1:0]  winner;

  logic [3:0][14:0] ws_counts;
  logic [1:0]       ws_win;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  bit armed = 1'b0;

  turf_ram_sched_if #(.ADDR_W(15)) ram_if ();

  turf_ram_sched dut (
    .CLOCK_50 (clk),      .resetn   (resetn),
    .start    (start),    .move_tick(move_tick), .sec_tick(sec_tick),
    .p1       (p1),       .p2       (p2),        .p3      (p3),       .p4(p4),
    .bus      (ram_if),
    .running  (running),  .done     (done),      .time_left(time_left),
    .p1_count (p1_count), .p2_count (p2_count),
    .p3_count (p3_count), .p4_count (p4_count),
    .winner   (winner)
  );

  winner_select u_ws (.counts(ws_counts), .winner(ws_win));

  always #10 clk = ~clk;

  // Paint RAM device with registered read
  logic [2:0] dev_mem [0:32767];
  always @(posedge clk) begin
    if (ram_if.ram_wren) dev_mem[ram_if.ram_addr] <= ram_if.ram_wdata;
    ram_if.ram_rdata <= dev_mem[ram_if.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural round model ----------------
  typedef struct packed { logic [14:0] a; logic [2:0] c; } wr_t;
  wr_t        wq[$];
  logic [2:0] mram [0:32767];
  int ph = P_IDLE, clr_a = 0, sw_a = 0, tl = 0;
  bit pend = 1'b0;
  int exp_cnt[4];
  int exp_win = 0;

  task automatic push_burst();
    wq.push_back({p1, 3'b001});
    wq.push_back({p2, 3'b010});
    wq.push_back({p3, 3'b100});
    wq.push_back({p4, 3'b110});
  endtask

  task automatic tally();
    int best;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    for (int a = 0; a <= LAST; a++) begin
      case (mram[a])
        3'b001: exp_cnt[0]++;
        3'b010: exp_cnt[1]++;
        3'b100: exp_cnt[2]++;
        3'b110: exp_cnt[3]++;
        default: ;
      endcase
    end
    exp_win = 0;
    best = exp_cnt[0];
    for (int i = 1; i < 4; i++)
      if (exp_cnt[i] >= best) begin best = exp_cnt[i]; exp_win = i; end
  endtask

  always @(posedge clk) begin : model
    int  told;
    bit  writing;
    wr_t w;
    if (!resetn) begin
      ph = P_IDLE; wq.delete(); pend = 1'b0; tl = 0; exp_win = 0;
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    end else begin
      case (ph)
        P_IDLE, P_DONE: if (start) begin ph = P_CLEAR; clr_a = 0; tl = ROUND; end
        P_CLEAR: begin
          mram[clr_a] = 3'b000;
          if (clr_a == LAST) ph = P_PLAY; else clr_a++;
        end
        P_PLAY: begin
          told = tl;
          writing = (wq.size() != 0);
          if (sec_tick && tl > 0) tl--;
          if (writing) begin
            w = wq.pop_front();
            mram[w.a] = w.c;
            if (wq.size() != 0) begin
              if (move_tick) pend = 1'b1;
            end else if (told == 0) begin
              ph = P_SWEEP; sw_a = 0; pend = 1'b0;
            end else if (pend || move_tick) begin
              push_burst(); pend = 1'b0;
            end
          end else if (told == 0) begin
            ph = P_SWEEP; sw_a = 0; pend = 1'b0;
          end else if (move_tick) begin
            push_burst();
          end
        end
        P_SWEEP: if (sw_a == LAST) ph = P_DRAIN; else sw_a++;
        P_DRAIN: begin ph = P_DONE; tally(); end
        default: ph = P_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit e_wren;
    if (armed) begin
      e_wren = (ph == P_CLEAR) || (ph == P_PLAY && wq.size() != 0);
      chk("wren", ram_if.ram_wren, e_wren);
      if (ph == P_CLEAR) begin
        chk("clear_addr", ram_if.ram_addr, clr_a);
        chk("clear_data", ram_if.ram_wdata, 0);
      end else if (e_wren) begin
        chk("paint_addr", ram_if.ram_addr, wq[0].a);
        chk("paint_data", ram_if.ram_wdata, wq[0].c);
      end else if (ph == P_SWEEP) begin
        chk("sweep_addr", ram_if.ram_addr, sw_a);
      end
      chk("running", running, ph == P_PLAY);
      chk("done", done, ph == P_DONE);
      chk("time_left", time_left, tl);
      if (ph == P_DONE) begin
        chk("p1_count", p1_count, exp_cnt[0]);
        chk("p2_count", p2_count, exp_cnt[1]);
        chk("p3_count", p3_count, exp_cnt[2]);
        chk("p4_count", p4_count, exp_cnt[3]);
        chk("winner", winner, exp_win);
      end else if (ph != P_SWEEP && ph != P_DRAIN) begin
        chk("counts_zero", {p1_count | p2_count | p3_count | p4_count}, 0);
        if (ph == P_IDLE) chk("winner_idle", winner, 0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_p(input logic [14:0] a, input logic [14:0] b,
                       input logic [14:0] c, input logic [14:0] d);
    p1 = a; p2 = b; p3 = c; p4 = d;
  endtask

  task automatic wait_running(output int n);
    n = 0;
    while (!running && n < 20400) begin cyc(1); n++; end
  endtask

  logic [14:0] exp_a [4];
  logic [2:0]  exp_c [4];

  initial begin
    int n;
    cyc(1);
    armed = 1'b1;
    chk("rst_wren", ram_if.ram_wren, 0);
    chk("rst_addr", ram_if.ram_addr, 0);
    chk("rst_wdata", ram_if.ram_wdata, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_time", time_left, 0);
    chk("rst_winner", winner, 0);
    cyc(1);
    resetn = 1'b1;
    cyc(2);

    // Round 1: clear, paint, time out mid-burst, sweep
    start = 1'b1; cyc(1); start = 1'b0;
    chk("clr_first_wren", ram_if.ram_wren, 1);
    chk("clr_first_addr", ram_if.ram_addr, 0);
    wait_running(n);
    chk("clear_cycles", n, 20344);
    chk("time_loaded", time_left, 60);

    set_p(15'h4EF6, 15'h0082, 15'h4E82, 15'h00F6);
    exp_a = '{15'h4EF6, 15'h0082, 15'h4E82, 15'h00F6};
    exp_c = '{3'b001, 3'b010, 3'b100, 3'b110};
    move_tick = 1'b1; cyc(1); move_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("burst_wren", ram_if.ram_wren, 1);
      chk("burst_addr", ram_if.ram_addr, exp_a[i]);
      chk("burst_data", ram_if.ram_wdata, exp_c[i]);
      cyc(1);
    end
    chk("burst_end_wren", ram_if.ram_wren, 0);

    set_p(15'h0001, 15'h0082, 15'h0003, 15'h00F6);
    move_tick = 1'b1; cyc(1); move_tick = 1'b0;
    cyc(2);
    set_p(15'h0005, 15'h0082, 15'h0006, 15'h00F6);
    move_tick = 1'b1; cyc(1);
    cyc(1); move_tick = 1'b0;
    chk("pending_no_gap_addr", ram_if.ram_addr, 15'h0005);
    chk("pending_no_gap_data", ram_if.ram_wdata, 3'b001);
    cyc(4);
    chk("third_tick_dropped", ram_if.ram_wren, 0);

    for (int i = 0; i < 59; i++) begin
      sec_tick = 1'b1; cyc(1); sec_tick = 1'b0; cyc(1);
    end
    chk("time_one_left", time_left, 1);

    set_p(15'h0001, 15'h0082, 15'h0011, 15'h00F6);
    move_tick = 1'b1; cyc(1); move_tick = 1'b0; cyc(4);

    set_p(15'h4EF6, 15'h0082, 15'h0010, 15'h00F6);
    move_tick = 1'b1; cyc(1); move_tick = 1'b0;
    cyc(1);
    sec_tick = 1'b1; cyc(1); sec_tick = 1'b0;
    chk("expire_mid_burst_time", time_left, 0);
    chk("expire_mid_burst_wren", ram_if.ram_wren, 1);
    cyc(2);
    chk("sweep_entry_wren", ram_if.ram_wren, 0);
    chk("sweep_entry_addr", ram_if.ram_addr, 0);
    chk("sweep_entry_running", running, 0);

    n = 0;
    while (!done && n < 20400) begin cyc(1); n++; end
    chk("sweep_cycles", n, 20345);
    chk("final_p1", p1_count, 3);
    chk("final_p2", p2_count, 1);
    chk("final_p3", p3_count, 5);
    chk("final_p4", p4_count, 1);
    chk("final_winner", winner, 2);
    chk("final_done", done, 1);
    cyc(3);
    chk("winner_holds", winner, 2);

    // Round 2: restart from DONE, abort with reset mid-sweep
    start = 1'b1; cyc(1); start = 1'b0;
    chk("restart_addr", ram_if.ram_addr, 0);
    chk("restart_done", done, 0);
    chk("restart_p3_zero", p3_count, 0);
    wait_running(n);
    chk("clear2_cycles", n, 20344);
    set_p(15'h0000, 15'h0001, 15'h0002, 15'h0003);
    move_tick = 1'b1; cyc(1); move_tick = 1'b0; cyc(4);
    for (int i = 0; i < 60; i++) begin
      sec_tick = 1'b1; cyc(1); sec_tick = 1'b0; cyc(1);
    end
    cyc(50);
    chk("mid_sweep_p1", p1_count, 1);
    chk("mid_sweep_p4", p4_count, 1);
    resetn = 1'b0; cyc(1);
    chk("abort_running", running, 0);
    chk("abort_done", done, 0);
    chk("abort_wren", ram_if.ram_wren, 0);
    chk("abort_addr", ram_if.ram_addr, 0);
    chk("abort_p1", p1_count, 0);
    chk("abort_p4", p4_count, 0);
    chk("abort_time", time_left, 0);
    resetn = 1'b1; cyc(1);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("reclear_addr0", ram_if.ram_addr, 0);
    chk("reclear_wren", ram_if.ram_wren, 1);
    cyc(3);
    chk("reclear_addr3", ram_if.ram_addr, 3);

    // Tie rule on the selector alone
    ws_counts = {15'd2, 15'd3, 15'd7, 15'd7}; #1; chk("tie_p1_p2", ws_win, 1);
    ws_counts = '0;                           #1; chk("all_zero", ws_win, 3);
    ws_counts = {15'd1, 15'd1, 15'd1, 15'd9}; #1; chk("p1_max", ws_win, 0);
    ws_counts = {15'd0, 15'd5, 15'd5, 15'd5}; #1; chk("tie_p1_p3", ws_win, 2);
    ws_counts = {15'd8, 15'd8, 15'd8, 15'd0}; #1; chk("tie_p2_p4", ws_win, 3);
    ws_counts = {15'd2, 15'd9, 15'd9, 15'd4}; #1; chk("tie_p2_p3", ws_win, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
